// File: rtl/nxn_board_game_ctrl.sv
// Two-player N x N N-in-a-row game controller: board storage, turn arbitration, win/draw detection.
// Latency: accepted move -> board updated 1 cycle; -> game_over or next move_ready 2 cycles.
// Backpressure: move_ready is high only while waiting for a move (TURN); moves offered elsewhere are not taken.
// Optional feature: define TURN_TIMEOUT_EN to end the game when a player exceeds TIMEOUT_CYCLES in TURN.
module nxn_board_game_ctrl #(
    parameter int N              = 3,
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CW            = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int MCW           = $clog2(N*N+1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               move_valid,
    input  logic [CW-1:0]      move_row,
    input  logic [CW-1:0]      move_col,
    output logic               move_ready,
    output logic               turn,
    output logic [2*N*N-1:0]   board,
    output logic [MCW-1:0]     move_count,
    output logic               illegal,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TURN  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int             CELLS      = N*N;
    localparam logic           FP         = (FIRST_PLAYER != 0);
    // One extra bit so an index equal to N (or above) can be compared for non-power-of-two N.
    localparam logic [CW:0]    N_EXT      = (CW+1)'(N);
    localparam logic [MCW-1:0] FULL_COUNT = MCW'(CELLS);

    logic [1:0]       state;
    logic [1:0]       mark;
    logic             in_range;
    logic             cell_occupied;
    logic [CELLS-1:0] target_sel;
    logic             take_move;
    logic             accept_legal;
    logic             reject_move;
    logic             tmo_hit;

    logic [N-1:0]     row_win;
    logic [N-1:0]     col_win;
    logic             diag_win;
    logic             anti_win;
    logic             mover_wins;

    // State decodes exposed directly; everything else leaves through a register.
    assign move_ready = (state == S_TURN);
    assign game_over  = (state == S_DONE);

    // Cell code of the player to move; during CHECK turn still names the player who just moved.
    assign mark = turn ? 2'b10 : 2'b01;

    assign in_range = ({1'b0, move_row} < N_EXT) && ({1'b0, move_col} < N_EXT);

    // Decode the addressed cell into a one-hot select and read back whether it is already taken.
    always_comb begin
        target_sel    = '0;
        cell_occupied = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if ((move_row == CW'(r)) && (move_col == CW'(c))) begin
                    target_sel[r*N+c] = 1'b1;
                    cell_occupied     = |board[2*(r*N+c) +: 2];
                end
            end
        end
    end

    assign take_move    = move_valid && move_ready;
    assign accept_legal = take_move && in_range && !cell_occupied;
    assign reject_move  = take_move && !(in_range && !cell_occupied);

    // Row and column ownership by the current mover; empty cells never match since mark is non-zero.
    always_comb begin
        row_win = '0;
        col_win = '0;
        for (int i = 0; i < N; i++) begin
            row_win[i] = 1'b1;
            col_win[i] = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (board[2*(i*N+j) +: 2] != mark) begin
                    row_win[i] = 1'b0;
                end
                if (board[2*(j*N+i) +: 2] != mark) begin
                    col_win[i] = 1'b0;
                end
            end
        end
    end

    // Main diagonal (r == c) and anti-diagonal (c == N-1-r) ownership by the current mover.
    always_comb begin
        diag_win = 1'b1;
        anti_win = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (board[2*(i*N+i) +: 2] != mark) begin
                diag_win = 1'b0;
            end
            if (board[2*(i*N+(N-1-i)) +: 2] != mark) begin
                anti_win = 1'b0;
            end
        end
    end

    assign mover_wins = (|row_win) || (|col_win) || diag_win || anti_win;

`ifdef TURN_TIMEOUT_EN
    localparam int             TCW      = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES-1);

    logic [TCW-1:0] turn_cnt;

    // Cycles spent in the current TURN; every other state holds it at zero so each TURN starts fresh.
    // Rejected moves leave TURN unchanged, so they do not restart the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            turn_cnt <= '0;
        end else if (state == S_TURN) begin
            turn_cnt <= turn_cnt + 1'b1;
        end else begin
            turn_cnt <= '0;
        end
    end

    // A legal move on the last allowed cycle beats the timeout.
    assign tmo_hit = (state == S_TURN) && (turn_cnt == TMO_LAST) && !accept_legal;
`else
    assign tmo_hit = 1'b0;
`endif

    // Game FSM with board, turn, move count and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            board      <= '0;
            turn       <= FP;
            move_count <= '0;
            illegal    <= 1'b0;
            winner     <= 2'b00;
            timeout    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        board      <= '0;
                        move_count <= '0;
                        winner     <= 2'b00;
                        timeout    <= 1'b0;
                        turn       <= FP;
                        state      <= S_TURN;
                    end
                end
                S_TURN: begin
                    if (accept_legal) begin
                        for (int i = 0; i < CELLS; i++) begin
                            if (target_sel[i]) begin
                                board[2*i +: 2] <= mark;
                            end
                        end
                        move_count <= move_count + 1'b1;
                        state      <= S_CHECK;
                    end else begin
                        if (reject_move) begin
                            illegal <= 1'b1;
                        end
                        if (tmo_hit) begin
                            winner  <= turn ? 2'b01 : 2'b10;
                            timeout <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_CHECK: begin
                    // A win on the last free cell is reported as a win, not a draw.
                    if (mover_wins) begin
                        winner <= mark;
                        state  <= S_DONE;
                    end else if (move_count == FULL_COUNT) begin
                        winner <= 2'b11;
                        state  <= S_DONE;
                    end else begin
                        turn  <= ~turn;
                        state <= S_TURN;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nxn_board_game_ctrl.sv
// Directed bench for nxn_board_game_ctrl: a 3x3 instance (first player 0) and a 4x4 instance (first player 1).
// Inputs are driven 1 time unit after each rising edge and outputs are sampled at the same point.
// Every comparison is an immediate assertion; the summary line reports totals.
module tb_nxn_board_game_ctrl;

    logic        clock = 1'b0;
    logic        reset;

    logic        s3_start, s3_valid;
    logic [1:0]  s3_row, s3_col;
    logic        s3_ready, s3_turn, s3_illegal, s3_over, s3_timeout;
    logic [17:0] s3_board;
    logic [3:0]  s3_mc;
    logic [1:0]  s3_winner;

    logic        s4_start, s4_valid;
    logic [1:0]  s4_row, s4_col;
    logic        s4_ready, s4_turn, s4_illegal, s4_over, s4_timeout;
    logic [31:0] s4_board;
    logic [4:0]  s4_mc;
    logic [1:0]  s4_winner;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    nxn_board_game_ctrl #(.N(3), .FIRST_PLAYER(0), .TIMEOUT_CYCLES(8)) dut3 (
        .clock(clock), .reset(reset), .start(s3_start), .move_valid(s3_valid),
        .move_row(s3_row), .move_col(s3_col), .move_ready(s3_ready), .turn(s3_turn),
        .board(s3_board), .move_count(s3_mc), .illegal(s3_illegal), .game_over(s3_over),
        .winner(s3_winner), .timeout(s3_timeout)
    );

    nxn_board_game_ctrl #(.N(4), .FIRST_PLAYER(1), .TIMEOUT_CYCLES(8)) dut4 (
        .clock(clock), .reset(reset), .start(s4_start), .move_valid(s4_valid),
        .move_row(s4_row), .move_col(s4_col), .move_ready(s4_ready), .turn(s4_turn),
        .board(s4_board), .move_count(s4_mc), .illegal(s4_illegal), .game_over(s4_over),
        .winner(s4_winner), .timeout(s4_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Offer a move to the 3x3 instance, then let the CHECK cycle pass.
    task automatic play3(input logic [1:0] r, input logic [1:0] c);
        chk("ready3_before_move", s3_ready, 1'b1);
        s3_valid = 1'b1; s3_row = r; s3_col = c;
        tick(1);
        s3_valid = 1'b0;
        tick(1);
    endtask

    task automatic play4(input logic [1:0] r, input logic [1:0] c);
        chk("ready4_before_move", s4_ready, 1'b1);
        s4_valid = 1'b1; s4_row = r; s4_col = c;
        tick(1);
        s4_valid = 1'b0;
        tick(1);
    endtask

    initial begin
        reset = 1'b1;
        s3_start = 1'b0; s3_valid = 1'b0; s3_row = 2'd0; s3_col = 2'd0;
        s4_start = 1'b0; s4_valid = 1'b0; s4_row = 2'd0; s4_col = 2'd0;
        #1;
        // Reset state
        chk("rst_board", s3_board, 18'h0);
        chk("rst_mc", s3_mc, 4'd0);
        chk("rst_turn", s3_turn, 1'b0);
        chk("rst_winner", s3_winner, 2'b00);
        chk("rst_illegal", s3_illegal, 1'b0);
        chk("rst_ready", s3_ready, 1'b0);
        chk("rst_over", s3_over, 1'b0);
        chk("rst_timeout", s3_timeout, 1'b0);
        chk("rst_turn4", s4_turn, 1'b1);
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("idle_hold_ready", s3_ready, 1'b0);

        // Game 1: P0 wins on row 0
        s3_start = 1'b1;
        tick(1);
        s3_start = 1'b0;
        chk("g1_ready", s3_ready, 1'b1);
        chk("g1_turn", s3_turn, 1'b0);
        s3_valid = 1'b1; s3_row = 2'd0; s3_col = 2'd0;
        tick(1);
        s3_valid = 1'b0;
        chk("g1_first_cell", s3_board[1:0], 2'b01);
        chk("g1_check_not_ready", s3_ready, 1'b0);
        chk("g1_mc1", s3_mc, 4'd1);
        tick(1);
        chk("g1_turn_p1", s3_turn, 1'b1);
        play3(2'd1, 2'd0);
        play3(2'd0, 2'd1);
        play3(2'd1, 2'd1);
        s3_valid = 1'b1; s3_row = 2'd0; s3_col = 2'd2;
        tick(1);
        s3_valid = 1'b0;
        chk("g1_over_early", s3_over, 1'b0);
        tick(1);
        chk("g1_over", s3_over, 1'b1);
        chk("g1_winner", s3_winner, 2'b01);
        chk("g1_mc", s3_mc, 4'd5);
        chk("g1_row0", s3_board[5:0], 6'b010101);
        chk("g1_board", s3_board, 18'h00295);
        // DONE ignores moves
        s3_valid = 1'b1; s3_row = 2'd2; s3_col = 2'd2;
        tick(1);
        s3_valid = 1'b0;
        chk("done_ign_board", s3_board, 18'h00295);
        chk("done_ign_mc", s3_mc, 4'd5);
        chk("done_hold_over", s3_over, 1'b1);

        // Game 2: start from DONE, occupied-cell and out-of-range rejects
        s3_start = 1'b1;
        tick(1);
        s3_start = 1'b0;
        chk("g2_board_clr", s3_board, 18'h0);
        chk("g2_turn", s3_turn, 1'b0);
        chk("g2_mc", s3_mc, 4'd0);
        chk("g2_winner", s3_winner, 2'b00);
        chk("g2_ready", s3_ready, 1'b1);
        play3(2'd1, 2'd1);
        chk("g2_turn_p1", s3_turn, 1'b1);
        s3_valid = 1'b1; s3_row = 2'd1; s3_col = 2'd1;
        tick(1);
        s3_valid = 1'b0;
        chk("occ_illegal", s3_illegal, 1'b1);
        chk("occ_turn", s3_turn, 1'b1);
        chk("occ_mc", s3_mc, 4'd1);
        chk("occ_ready", s3_ready, 1'b1);
        tick(1);
        chk("occ_pulse_end", s3_illegal, 1'b0);
        s3_valid = 1'b1; s3_row = 2'd2; s3_col = 2'd2;
        tick(1);
        s3_valid = 1'b0;
        chk("retry_mc", s3_mc, 4'd2);
        chk("retry_illegal", s3_illegal, 1'b0);
        tick(1);
        chk("retry_board", s3_board, 18'h20100);
        chk("retry_turn", s3_turn, 1'b0);
        s3_valid = 1'b1; s3_row = 2'd3; s3_col = 2'd0;
        tick(1);
        s3_valid = 1'b0;
        chk("oor_illegal", s3_illegal, 1'b1);
        chk("oor_board", s3_board, 18'h20100);
        chk("oor_mc", s3_mc, 4'd2);
        tick(1);

        // Reset while in CHECK
        s3_valid = 1'b1; s3_row = 2'd0; s3_col = 2'd0;
        tick(1);
        s3_valid = 1'b0;
        chk("pre_rst_check", s3_ready, 1'b0);
        chk("pre_rst_board", s3_board, 18'h20101);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_board", s3_board, 18'h0);
        chk("mid_rst_ready", s3_ready, 1'b0);
        chk("mid_rst_over", s3_over, 1'b0);
        chk("mid_rst_mc", s3_mc, 4'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        tick(1);
        chk("post_rst_idle", s3_ready, 1'b0);

        // Game 3: draw
        s3_start = 1'b1;
        tick(1);
        s3_start = 1'b0;
        play3(2'd0, 2'd0);
        play3(2'd0, 2'd1);
        play3(2'd0, 2'd2);
        play3(2'd1, 2'd1);
        play3(2'd1, 2'd0);
        play3(2'd1, 2'd2);
        play3(2'd2, 2'd1);
        play3(2'd2, 2'd0);
        chk("draw_not_over", s3_over, 1'b0);
        play3(2'd2, 2'd2);
        chk("draw_winner", s3_winner, 2'b11);
        chk("draw_mc", s3_mc, 4'd9);
        chk("draw_over", s3_over, 1'b1);
        chk("draw_board", s3_board, 18'b010110101001011001);

        // Turn time limit
        s3_start = 1'b1;
        tick(1);
        s3_start = 1'b0;
`ifdef TURN_TIMEOUT_EN
        tick(7);
        chk("tmo_not_yet", s3_over, 1'b0);
        tick(1);
        chk("tmo_over", s3_over, 1'b1);
        chk("tmo_winner", s3_winner, 2'b10);
        chk("tmo_flag", s3_timeout, 1'b1);
        chk("tmo_mc", s3_mc, 4'd0);
        s3_start = 1'b1;
        tick(1);
        s3_start = 1'b0;
        chk("tmo_restart_clr", s3_timeout, 1'b0);
        tick(7);
        s3_valid = 1'b1; s3_row = 2'd0; s3_col = 2'd0;
        tick(1);
        s3_valid = 1'b0;
        chk("tmo_move_wins_flag", s3_timeout, 1'b0);
        chk("tmo_move_wins_mc", s3_mc, 4'd1);
        chk("tmo_move_wins_cell", s3_board[1:0], 2'b01);
        chk("tmo_move_wins_over", s3_over, 1'b0);
        tick(1);
        chk("tmo_move_next_turn", s3_turn, 1'b1);
        chk("tmo_move_next_ready", s3_ready, 1'b1);
`else
        tick(20);
        chk("wait_ready", s3_ready, 1'b1);
        chk("wait_over", s3_over, 1'b0);
        chk("wait_timeout", s3_timeout, 1'b0);
`endif

        // 4x4, player 1 first, wins on the anti-diagonal
        s4_start = 1'b1;
        tick(1);
        s4_start = 1'b0;
        chk("g4_turn", s4_turn, 1'b1);
        play4(2'd0, 2'd3);
        play4(2'd0, 2'd0);
        play4(2'd1, 2'd2);
        play4(2'd0, 2'd1);
        play4(2'd2, 2'd1);
        play4(2'd1, 2'd0);
        chk("g4_not_over", s4_over, 1'b0);
        play4(2'd3, 2'd0);
        chk("g4_over", s4_over, 1'b1);
        chk("g4_winner", s4_winner, 2'b10);
        chk("g4_mc", s4_mc, 5'd7);
        chk("g4_board", s4_board, 32'h02082185);
        chk("g4_illegal", s4_illegal, 1'b0);
        chk("g4_timeout", s4_timeout, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
